// File: rtl/clause_table_loader_if.sv
// Beat stream into the clause table loader: master drives payload, slave returns ready.
// A beat transfers on any cycle where valid and ready are both high.
interface clause_table_loader_if #(
   parameter int DATA_WIDTH = 32
) ();
   logic                  valid;
   logic                  ready;
   logic                  last;
   logic [DATA_WIDTH-1:0] data;

   modport master (output valid, output data, output last, input ready);
   modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/clause_table_loader.sv
// Packs BEATS stream beats into one clause table row and writes it; write strobe lands the cycle after
// a row's last beat. Stream is back-pressured (ready low) outside COLLECT, so BEATS+1 cycles per row at best.
module clause_table_loader #(
   parameter int CLAUSE_COUNT           = 20,
   parameter int DEPTH                  = 2048,
   parameter int VARIABLE_ADDRESS_WIDTH = 11,
   parameter int NSAT                   = 3,
   parameter int DATA_WIDTH             = 32,
   localparam int CT_WIDTH = (VARIABLE_ADDRESS_WIDTH + 1) * (NSAT - 1) * CLAUSE_COUNT,
   localparam int BEATS    = (CT_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              start_i,
   input  logic [VARIABLE_ADDRESS_WIDTH-1:0] base_addr_i,
   input  logic [VARIABLE_ADDRESS_WIDTH:0]   row_count_i,
   clause_table_loader_if.slave              s,
   output logic                              axi_wr_en_o,
   output logic [VARIABLE_ADDRESS_WIDTH-1:0] axi_wr_addr_o,
   output logic [CT_WIDTH-1:0]               axi_wr_clauses_o,
   output logic                              busy_o,
   output logic                              done_o,
   output logic                              err_o
);
   localparam int VAW = VARIABLE_ADDRESS_WIDTH;
   localparam int BCW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [VAW:0] ROW_ONE = 1;

   if (DEPTH > (1 << VAW)) begin : g_depth_chk
      $error("clause table DEPTH exceeds the row address space");
   end

   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

   state_t                  state_q, state_d;
   logic [BCW-1:0]          beat_cnt_q;
   logic [VAW:0]            row_cnt_q;
   logic [VAW:0]            row_count_q;
   logic [VAW-1:0]          base_q;
   logic [BEATS*DATA_WIDTH-1:0] row_q;
   logic                    beat_acc;
   logic                    row_full;
   logic                    last_row;

   assign s.ready          = (state_q == COLLECT);
   assign busy_o           = (state_q != IDLE);
   assign axi_wr_clauses_o = row_q[CT_WIDTH-1:0];

   always_comb begin
      state_d  = state_q;
      beat_acc = s.valid && (state_q == COLLECT);
      row_full = (beat_cnt_q == BCW'(BEATS - 1));
      last_row = ((row_cnt_q + ROW_ONE) == row_count_q);
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = (row_count_i == '0) ? DONE : COLLECT;
            end
         end
         COLLECT: begin
            if (beat_acc && row_full) begin
               state_d = WRITE;
            end
         end
         WRITE:   state_d = last_row ? DONE : COLLECT;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         beat_cnt_q    <= '0;
         row_cnt_q     <= '0;
         row_count_q   <= '0;
         base_q        <= '0;
         row_q         <= '0;
         axi_wr_en_o   <= 1'b0;
         axi_wr_addr_o <= '0;
         done_o        <= 1'b0;
         err_o         <= 1'b0;
      end else begin
         state_q     <= state_d;
         axi_wr_en_o <= (state_d == WRITE);
         done_o      <= (state_d == DONE);
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  base_q      <= base_addr_i;
                  row_count_q <= row_count_i;
                  err_o       <= 1'b0;
                  beat_cnt_q  <= '0;
                  row_cnt_q   <= '0;
               end
            end
            COLLECT: begin
               if (beat_acc) begin
                  for (int b = 0; b < BEATS; b++) begin
                     if (beat_cnt_q == BCW'(b)) begin
                        row_q[b*DATA_WIDTH +: DATA_WIDTH] <= s.data;
                     end
                  end
                  beat_cnt_q <= row_full ? '0 : beat_cnt_q + BCW'(1);
                  // last must coincide exactly with the final beat of the final row
                  if (s.last != (row_full && last_row)) begin
                     err_o <= 1'b1;
                  end
                  if (row_full) begin
                     axi_wr_addr_o <= base_q + row_cnt_q[VAW-1:0];
                  end
               end
            end
            WRITE:   row_cnt_q <= row_cnt_q + ROW_ONE;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_clause_table_loader.sv
// Bench for clause_table_loader: table of loads checked against a row/address model, plus reset,
// zero-count and start-while-busy sequences.
module tb_clause_table_loader;
   localparam int VAW   = 11;
   localparam int DW    = 32;
   localparam int BEATS = 15;
   localparam int CT    = 480;

   typedef logic [CT-1:0] wide_t;

   typedef struct {
      int base;
      int rows;
      int gap;
      int lastpos;
      bit fixed;
      bit exp_err;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic [VAW-1:0] base;
   logic [VAW:0]   cnt;
   logic           wr_en;
   logic [VAW-1:0] wr_addr;
   logic [CT-1:0]  wr_clauses;
   logic           busy, done, err;

   always #5 clk = ~clk;

   clause_table_loader_if #(.DATA_WIDTH(DW)) ifc ();

   clause_table_loader dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .start_i          (start),
      .base_addr_i      (base),
      .row_count_i      (cnt),
      .s                (ifc),
      .axi_wr_en_o      (wr_en),
      .axi_wr_addr_o    (wr_addr),
      .axi_wr_clauses_o (wr_clauses),
      .busy_o           (busy),
      .done_o           (done),
      .err_o            (err)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int wr_seen = 0;
   int wr_exp = 0;
   logic [VAW-1:0] exp_addr[$];
   wide_t          exp_rows[$];
   logic [DW-1:0]  beats[$];
   vec_t           vecs[7];

   task automatic chk(input string name, input wide_t act, input wide_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Every write strobe must match the next row the model predicts
   always @(negedge clk) begin
      if (rst_n === 1'b1 && wr_en === 1'b1) begin
         wr_seen++;
         chk("ready_in_write", wide_t'(ifc.ready), wide_t'(0));
         if (exp_rows.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_write: addr %0d, no write expected", wr_addr);
         end else begin
            chk("wr_addr", wide_t'(wr_addr), wide_t'(exp_addr.pop_front()));
            chk("wr_data", wr_clauses, exp_rows.pop_front());
         end
      end
   end

   task automatic prep(input int b, input int rows, input bit fixed);
      beats.delete();
      for (int r = 0; r < rows; r++) begin
         wide_t row;
         row = '0;
         for (int k = 0; k < BEATS; k++) begin
            logic [DW-1:0] d;
            d = fixed ? DW'(k + 1) : DW'($urandom);
            beats.push_back(d);
            row[k*DW +: DW] = d;
         end
         exp_rows.push_back(row);
         exp_addr.push_back(VAW'((b + r) % (1 << VAW)));
         wr_exp++;
      end
   endtask

   task automatic do_start(input int b, input int rows);
      start = 1'b1;
      base  = VAW'(b);
      cnt   = (VAW + 1)'(rows);
      @(negedge clk);
      start = 1'b0;
      chk("err_cleared", wide_t'(err), wide_t'(0));
      chk("busy_after_start", wide_t'(busy), wide_t'(1));
   endtask

   task automatic drive_beat(input int b, input int gap, input int lastpos);
      ifc.valid = ($urandom_range(99) >= gap);
      ifc.data  = beats[b];
      ifc.last  = (b == lastpos);
   endtask

   task automatic stream(input int gap, input int lastpos);
      int b;
      int t;
      bit hs;
      b = 0;
      t = 0;
      drive_beat(0, gap, lastpos);
      while (b < beats.size()) begin
         hs = ifc.valid && ifc.ready;
         @(negedge clk);
         t++;
         if (hs) begin
            if ((b % BEATS) == BEATS - 1) chk("wr_latency", wide_t'(wr_en), wide_t'(1));
            b++;
         end
         if (t > 2000) begin
            n_cmp++;
            n_fail++;
            $display("FAIL stream_timeout: %0d beats accepted, %0d required", b, beats.size());
            break;
         end
         if (b < beats.size()) begin
            if (hs || !ifc.valid) drive_beat(b, gap, lastpos);
         end else begin
            ifc.valid = 1'b0;
            ifc.last  = 1'b0;
         end
      end
      ifc.valid = 1'b0;
      ifc.last  = 1'b0;
   endtask

   task automatic wait_done(input bit exp_err);
      int t;
      t = 0;
      while (done !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("done_seen", wide_t'(done), wide_t'(1));
      chk("err", wide_t'(err), wide_t'(exp_err));
      chk("rows_pending", wide_t'(exp_rows.size()), wide_t'(0));
      chk("write_count", wide_t'(wr_seen), wide_t'(wr_exp));
      @(negedge clk);
      chk("busy_after_done", wide_t'(busy), wide_t'(0));
      chk("done_one_cycle", wide_t'(done), wide_t'(0));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"},   wide_t'(ifc.ready), wide_t'(0));
      chk({tag, "_wr_en"},   wide_t'(wr_en), wide_t'(0));
      chk({tag, "_wr_addr"}, wide_t'(wr_addr), wide_t'(0));
      chk({tag, "_wr_data"}, wr_clauses, wide_t'(0));
      chk({tag, "_busy"},    wide_t'(busy), wide_t'(0));
      chk({tag, "_done"},    wide_t'(done), wide_t'(0));
      chk({tag, "_err"},     wide_t'(err), wide_t'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      //            base  rows gap lastpos fixed err
      vecs[0] = '{5,    1,   0,  14,     1,    0};
      vecs[1] = '{2046, 3,   0,  44,     0,    0};
      vecs[2] = '{300,  2,   50, 29,     0,    0};
      vecs[3] = '{7,    2,   0,  22,     0,    1};
      vecs[4] = '{1000, 1,   0,  14,     0,    0};
      vecs[5] = '{2040, 4,   30, 59,     0,    0};
      vecs[6] = '{0,    2,   70, 99,     0,    1};

      rst_n = 1'b0;
      start = 1'b0;
      base  = '0;
      cnt   = '0;
      ifc.valid = 1'b0;
      ifc.data  = '0;
      ifc.last  = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         prep(vecs[i].base, vecs[i].rows, vecs[i].fixed);
         do_start(vecs[i].base, vecs[i].rows);
         stream(vecs[i].gap, vecs[i].lastpos);
         wait_done(vecs[i].exp_err);
      end

      // Zero-row load: straight to DONE, nothing consumed or written
      start = 1'b1;
      base  = VAW'(9);
      cnt   = '0;
      @(negedge clk);
      start = 1'b0;
      chk("zero_done", wide_t'(done), wide_t'(1));
      chk("zero_ready", wide_t'(ifc.ready), wide_t'(0));
      chk("zero_busy", wide_t'(busy), wide_t'(1));
      @(negedge clk);
      chk("zero_done_end", wide_t'(done), wide_t'(0));
      chk("zero_busy_end", wide_t'(busy), wide_t'(0));
      chk("zero_ready_end", wide_t'(ifc.ready), wide_t'(0));
      chk("zero_no_write", wide_t'(wr_seen), wide_t'(wr_exp));

      // A second start while busy must not retarget the load
      prep(10, 1, 0);
      do_start(10, 1);
      start = 1'b1;
      base  = VAW'(500);
      cnt   = (VAW + 1)'(5);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      stream(0, 14);
      wait_done(0);

      // Reset mid-row: partial row dropped, no write, all outputs cleared
      do_start(100, 2);
      for (int k = 0; k < 8; k++) begin
         ifc.valid = 1'b1;
         ifc.data  = DW'($urandom);
         ifc.last  = 1'b0;
         @(negedge clk);
      end
      ifc.valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midreset_no_write", wide_t'(wr_seen), wide_t'(wr_exp));

      prep(77, 2, 0);
      do_start(77, 2);
      stream(0, 29);
      wait_done(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
